// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the store write buffer:
// store opcode, instruction field helpers and drain FSM states.
package store_write_buffer_pkg;

  localparam logic [3:0] OP_SW = 4'b1010;
  localparam int OFF_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_e;

  function automatic logic is_sw(input logic [3:0] opc);
    return opc == OP_SW;
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Data-memory write port: request, address, data and acknowledge.
// The buffer drives the request side; memory returns the ack.
interface store_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/store_write_buffer_sync_fifo.sv
// Entry storage for the store buffer: circular FIFO with a
// lookahead port giving the entry that becomes head after a pop.
module store_write_buffer_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] nxt,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_nxt   = rd_ptr_q + PW'(1);
  end

  assign head  = mem_q[rd_ptr_q];
  // with a single entry the successor is whatever is being pushed now
  assign nxt   = (count_q > CW'(1)) ? mem_q[rd_nxt] : din;
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: address generation, entry queue, in-order
// drain FSM to data memory and sticky overflow flag.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int WIDTH  = ADDR_W + DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instruction,
  input  logic [31:0]   Read_register1,
  input  logic [31:0]   Read_register2,
  input  logic          write_enable,
  output logic          st_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  store_write_buffer_if.master mem
);

  drain_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               ovf_q, ovf_d;

  logic signed [OFF_W-1:0] off;
  logic [ADDR_W-1:0]  st_addr;
  logic [WIDTH-1:0]   entry, head, nxt;
  logic               is_store, push, pop, remain;
  logic               unused_bits;

  assign unused_bits = &{1'b0, instruction[11:6]};

  always_comb begin
    off      = instruction[OFF_W-1:0];
    st_addr  = Read_register1[ADDR_W-1:0] + ADDR_W'(off);
    entry    = {st_addr, Read_register2[DATA_W-1:0]};
    st_ready = count != CW'(DEPTH);
    is_store = write_enable && is_sw(instruction[15:12]);
    push     = is_store && st_ready;
    pop      = (state_q == REQ) && mem.mem_ack;
    remain   = (count != CW'(1)) || push;
    ovf_d    = ovf_q || (is_store && !st_ready);
  end

  store_write_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .head  (head),
    .nxt   (nxt),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d           = REQ;
          req_d             = 1'b1;
          {addr_d, wdata_d} = head;
        end
      end
      REQ: begin
        // hold the presented write until memory takes it
        if (mem.mem_ack) begin
          if (remain) begin
            {addr_d, wdata_d} = nxt;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed vector table, corner
// sequences and random traffic against a queue-based model.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction = '0;
  logic [31:0] Read_register1 = '0;
  logic [31:0] Read_register2 = '0;
  logic        write_enable = 1'b0;
  logic        st_ready;
  logic [2:0]  count;
  logic        overflow;

  store_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  store_write_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .Read_register1 (Read_register1),
    .Read_register2 (Read_register2),
    .write_enable   (write_enable),
    .st_ready       (st_ready),
    .count          (count),
    .overflow       (overflow),
    .mem            (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        we;
    logic [15:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ack;
    logic        ereq;
    logic [31:0] ea;
    logic [31:0] ed;
    int          ecnt;
  } vec_t;

  ent_t q[$];
  bit   busy;
  bit   ovf;
  int   errors = 0;
  int   checks = 0;
  int   retired = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    busy = 0;
    ovf  = 0;
  endtask

  task automatic model_cmp();
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_req", 64'(mif.mem_req), 64'(busy));
    chk("overflow", 64'(overflow), 64'(ovf));
    chk("st_ready", 64'(st_ready), 64'(q.size() != 4));
    if (busy && q.size() > 0) begin
      chk("mem_addr", 64'(mif.mem_addr), 64'(q[0].a));
      chk("mem_wdata", 64'(mif.mem_wdata), 64'(q[0].d));
    end
  endtask

  task automatic step(input logic we, input logic [15:0] ins,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ack);
    int   n0;
    bit   acc;
    int   off;
    ent_t e;
    write_enable   = we;
    instruction    = ins;
    Read_register1 = r1;
    Read_register2 = r2;
    mif.mem_ack    = ack;
    #1;
    chk("st_ready_pre", 64'(st_ready), 64'(q.size() != 4));
    if (mif.mem_req && ack) retired++;
    n0  = q.size();
    acc = busy && ack;
    if (acc) void'(q.pop_front());
    if (we && ins[15:12] == 4'hA) begin
      off = int'($signed(ins[5:0]));
      e.a = r1 + 32'(off);
      e.d = r2;
      if (n0 != 4) q.push_back(e);
      else ovf = 1;
    end
    busy = busy ? (!acc || q.size() != 0) : (n0 != 0);
    @(posedge clk);
    #1;
    model_cmp();
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    write_enable = 1'b1;
    instruction  = 16'hA001;
    Read_register1 = 32'h40;
    mif.mem_ack  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(mif.mem_req), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(mif.mem_addr), 64'd0);
    reset = 1'b1;
    model_clear();
  endtask

  vec_t tv[9];

  initial begin
    mif.mem_ack = 1'b0;
    tv[0] = '{1'b1, 16'hA005, 32'h100, 32'hDEAD, 1'b0,
              1'b0, 32'h0, 32'h0, 1};
    tv[1] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b0,
              1'b1, 32'h105, 32'hDEAD, 1};
    tv[2] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b0,
              1'b1, 32'h105, 32'hDEAD, 1};
    tv[3] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b0,
              1'b1, 32'h105, 32'hDEAD, 1};
    tv[4] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b0,
              1'b1, 32'h105, 32'hDEAD, 1};
    tv[5] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b1,
              1'b0, 32'h0, 32'h0, 0};
    tv[6] = '{1'b1, 16'hA03F, 32'h0, 32'h1234, 1'b0,
              1'b0, 32'h0, 32'h0, 1};
    tv[7] = '{1'b1, 16'hCCCC, 32'h5, 32'h9, 1'b0,
              1'b1, 32'hFFFF_FFFF, 32'h1234, 1};
    tv[8] = '{1'b0, 16'h0000, 32'h0, 32'h0, 1'b1,
              1'b0, 32'h0, 32'h0, 0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tv[i].we, tv[i].ins, tv[i].r1, tv[i].r2, tv[i].ack);
      chk($sformatf("tv%0d_count", i), 64'(count), 64'(tv[i].ecnt));
      chk($sformatf("tv%0d_req", i), 64'(mif.mem_req), 64'(tv[i].ereq));
      if (tv[i].ereq) begin
        chk($sformatf("tv%0d_addr", i), 64'(mif.mem_addr), 64'(tv[i].ea));
        chk($sformatf("tv%0d_wdata", i), 64'(mif.mem_wdata), 64'(tv[i].ed));
      end
    end

    for (int i = 0; i < 5; i++)
      step(1'b1, 16'hA000, 32'(i * 16), 32'(i + 1), 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(st_ready), 64'd0);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_head", 64'(mif.mem_addr), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
      chk($sformatf("drain%0d_count", k), 64'(count), 64'(4 - k));
    end
    step(1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);

    retired = 0;
    for (int i = 0; i < 20; i++)
      step(1'b1, 16'hA000 | 16'(i % 64), 32'h1000 + 32'(i * 4),
           32'hC000 + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
    chk("concurrent_retired", 64'(retired), 64'd20);

    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'hA002, 32'h200 + 32'(i * 8), 32'(i), 1'b0);
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_req", 64'(mif.mem_req), 64'd1);
    write_enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_req", 64'(mif.mem_req), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
    chk("no_stale_req", 64'(mif.mem_req), 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(3) != 0) ins[15:12] = 4'hA;
      step(($urandom_range(3) != 0), ins, $urandom, $urandom,
           1'($urandom_range(1)));
    end
    for (int i = 0; i < 6; i++)
      step(1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);
    chk("final_empty", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
